// File: rtl/axis_upsizer_pkg.sv
// Shared helpers for the AXI-stream upsizer: width derivation for the lane counter.
package axis_upsizer_pkg;

  // Number of bits needed to hold values 0..value (at least one bit).
  function automatic int unsigned bits_for(input int unsigned value);
    int unsigned bits;
    bits = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axis_upsizer_counter.sv
// Bounded up-counter with synchronous reset to INIT_VALUE and optional wrap from UPPER to LOWER.
module axis_upsizer_counter #(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned LOWER      = 0,
  parameter int unsigned UPPER      = 3,
  parameter bit          WRAPAROUND = 1'b1,
  parameter int unsigned INIT_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= WIDTH'(INIT_VALUE);
    end else if (ena) begin
      if (value == WIDTH'(UPPER)) begin
        if (WRAPAROUND) value <= WIDTH'(LOWER);
      end else begin
        value <= value + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI-stream beats into one wide beat; tlast flushes a partial word with a keep mask.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]            m_axis_tkeep,
  output logic                        m_axis_tlast
);

  localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
  localparam int unsigned CNT_WIDTH = bits_for(RATIO - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic [RATIO-1:0]     acc_keep;
  logic [RATIO-1:0]     merged_keep;
  logic                 last_lane;
  logic                 out_free;
  logic                 accept;
  logic                 closing;

  assign last_lane     = (cnt == CNT_WIDTH'(RATIO - 1));
  assign out_free      = ~m_axis_tvalid | m_axis_tready;
  // Non-final beats may land in the accumulator even while the output is stalled.
  assign s_axis_tready = ena & (out_free | (~last_lane & ~s_axis_tlast));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign closing       = accept & (last_lane | s_axis_tlast);

  // Lane counter; tlast forces an early return to lane 0.
  axis_upsizer_counter #(
    .WIDTH      (CNT_WIDTH),
    .LOWER      (0),
    .UPPER      (RATIO - 1),
    .WRAPAROUND (1'b1),
    .INIT_VALUE (0)
  ) u_lane_cnt (
    .clk   (clk),
    .rst   (rst | (ena & accept & s_axis_tlast)),
    .ena   (ena & accept),
    .value (cnt)
  );

  // Current beat merged into the accumulator at lane cnt.
  always_comb begin
    merged      = acc;
    merged_keep = acc_keep;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt == CNT_WIDTH'(i)) begin
        merged[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
        merged_keep[i]                     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      acc_keep      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (ena) begin
      if (closing) begin
        // Load replaces any word being consumed this cycle, so no bubble.
        m_axis_tdata  <= merged;
        m_axis_tkeep  <= merged_keep;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tvalid <= 1'b1;
        acc           <= '0;
        acc_keep      <= '0;
      end else begin
        if (accept) begin
          acc      <= merged;
          acc_keep <= merged_keep;
        end
        if (m_axis_tready) m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
